bcd_seg_display: RTL and testbench

// - Consumes the 5-bit BCD result of the Gray/binary-to-BCD converter (bit4 = tens digit 0/1, bits3:0 = units digit).
// - Drives a 2-digit multiplexed 7-segment display with time-sliced scanning and an anti-ghosting blank gap.
// - Holds one pending word so a new value takes effect only at a digit boundary, never mid-digit.

---
 rtl/bcd_disp_pkg.sv | 27 ++
 rtl/bcd_to_seg7.sv | 17 +
 rtl/bcd_seg_display.sv | 135 +++++++++++++
 tb/tb_bcd_seg_display.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the 2-digit BCD 7-segment display.
package bcd_disp_pkg;

    // Scan phases: each digit slot is followed by an all-off guard gap.
    typedef enum logic [1:0] {
        UNITS = 2'd0,
        GAP_A = 2'd1,
        TENS  = 2'd2,
        GAP_B = 2'd3
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Index 0 sits in the least significant slice, so SEG_DIGITS[n] is digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Digit enable patterns, bit order {tens, units}, active-high.
    localparam logic [1:0] DIG_OFF   = 2'b00;
    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment decoder; 10..15 show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for legal digits, dash for anything out of range.
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/bcd_seg_display.sv
// Two-digit multiplexed 7-segment driver with guard gaps and a one-word
// pending buffer that is only committed to the display at a gap boundary.
module bcd_seg_display
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_bcd,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       err
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GUARD_CYCLES - 1);

    // Output polarity masks; XOR with an active-high pattern gives the pin value.
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_POL = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       pend, pend_nxt;
    logic             pend_full, pend_full_nxt;
    logic [4:0]       shown, shown_nxt;
    logic [6:0]       seg_nxt;
    logic [1:0]       dig_nxt;
    logic             err_nxt;

    logic [6:0]       units_seg;
    logic [6:0]       tens_seg;
    logic             last_cycle;
    logic             in_gap;

    bcd_to_seg7 u_units_dec (
        .bcd (shown[3:0]),
        .seg (units_seg)
    );

    // The pending slot is the only back-pressure source.
    assign in_ready = !pend_full;

    // Tens digit only ever shows 1, 0 or nothing.
    assign tens_seg = shown[4]      ? SEG_DIGITS[1] :
                      BLANK_LEADING ? SEG_BLANK     : SEG_DIGITS[0];

    assign in_gap     = (state == GAP_A) || (state == GAP_B);
    assign last_cycle = in_gap ? (cnt == GAP_LAST) : (cnt == DIGIT_LAST);

    // Next-state, buffer handshake and next output values.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_W'(1);
        pend_nxt      = pend;
        pend_full_nxt = pend_full;
        shown_nxt     = shown;
        seg_nxt       = SEG_BLANK;
        dig_nxt       = DIG_OFF;
        err_nxt       = (shown[3:0] > 4'd9);

        if (last_cycle) begin
            cnt_nxt = '0;
            unique case (state)
                UNITS:   state_nxt = GAP_A;
                GAP_A:   state_nxt = TENS;
                TENS:    state_nxt = GAP_B;
                default: state_nxt = UNITS;
            endcase
        end

        // Commit happens only at the end of a gap, so a digit never changes mid-slot.
        // Accept and commit are mutually exclusive because accept needs an empty slot.
        if (in_gap && last_cycle && pend_full) begin
            shown_nxt     = pend;
            pend_full_nxt = 1'b0;
        end else if (in_valid && !pend_full) begin
            pend_nxt      = in_bcd;
            pend_full_nxt = 1'b1;
        end

        unique case (state)
            UNITS: begin
                dig_nxt = DIG_UNITS;
                seg_nxt = units_seg;
            end
            TENS: begin
                dig_nxt = DIG_TENS;
                seg_nxt = tens_seg;
            end
            default: begin
                dig_nxt = DIG_OFF;
                seg_nxt = SEG_BLANK;
            end
        endcase
    end

    // State, buffer and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= UNITS;
            cnt       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            shown     <= '0;
            seg       <= SEG_BLANK ^ SEG_POL;
            dig       <= DIG_OFF ^ DIG_POL;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend      <= pend_nxt;
            pend_full <= pend_full_nxt;
            shown     <= shown_nxt;
            seg       <= seg_nxt ^ SEG_POL;
            dig       <= dig_nxt ^ DIG_POL;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed self-checking bench for bcd_seg_display with a short scan period
// (4-cycle digit slots, 1-cycle gaps, active-high pins, leading zero blanked).
module tb_bcd_seg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_bcd;
    logic       in_ready;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         k;          // edges since reset release
    logic [4:0] exp_val;    // value the display is expected to show
    logic [1:0] prev_dig;
    logic [6:0] seg_tab [16];

    bcd_seg_display #(
        .REFRESH_DIV    (4),
        .GUARD_CYCLES   (1),
        .BLANK_LEADING  (1'b1),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bcd   (in_bcd),
        .in_ready (in_ready),
        .seg      (seg),
        .dig      (dig),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, want, k);
        end
    endtask

    // Expected digit enables for an output reflecting scan cycle phase ph (0..9).
    function automatic logic [1:0] exp_dig(input int ph);
        if (ph < 4)       return 2'b01;
        else if (ph == 4) return 2'b00;
        else if (ph < 9)  return 2'b10;
        else              return 2'b00;
    endfunction

    function automatic logic [6:0] exp_seg(input int ph, input logic [4:0] v);
        if (ph < 4)       return seg_tab[v[3:0]];
        else if (ph == 4) return 7'h00;
        else if (ph < 9)  return v[4] ? 7'h06 : 7'h00;
        else              return 7'h00;
    endfunction

    // Clock until k reaches target, checking the scan pattern on every edge.
    task automatic run_to(input int target);
        int ph;
        while (k < target) begin
            @(posedge clk);
            #1;
            k++;
            ph = (k - 1) % 10;
            check("dig", {30'd0, dig}, {30'd0, exp_dig(ph)});
            check("seg", {25'd0, seg}, {25'd0, exp_seg(ph, exp_val)});
            check("dig_not_both", {31'd0, dig == 2'b11}, 32'd0);
            check("dig_via_gap", {31'd0, (dig != prev_dig) && (dig != 2'b00) && (prev_dig != 2'b00)}, 32'd0);
            if (ph != 4 && ph != 9) begin
                check("err", {31'd0, err}, {31'd0, exp_val[3:0] > 4'd9});
            end
            prev_dig = dig;
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bcd   = 5'd0;
        exp_val  = 5'd0;
        k        = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_dig",   {30'd0, dig},      32'd0);
        check("rst_seg",   {25'd0, seg},      32'd0);
        check("rst_err",   {31'd0, err},      32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        rst      = 1'b0;
        prev_dig = dig;

        // Idle scan: units '0', tens blank.
        run_to(21);
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // 13 sent mid-UNITS: slot unchanged, committed after GAP_A.
        in_valid = 1'b1;
        in_bcd   = 5'b1_0011;
        run_to(22);
        in_valid = 1'b0;
        check("w13_ready_low", {31'd0, in_ready}, 32'd0);
        run_to(24);
        check("w13_ready_held", {31'd0, in_ready}, 32'd0);
        run_to(25);
        check("w13_ready_back", {31'd0, in_ready}, 32'd1);
        exp_val = 5'b1_0011;
        run_to(46);

        // Back-to-back 5 then 7, second word held valid during back-pressure.
        in_valid = 1'b1;
        in_bcd   = 5'b0_0101;
        run_to(47);
        in_bcd   = 5'b0_0111;
        check("b2b_ready_low", {31'd0, in_ready}, 32'd0);
        run_to(50);
        check("b2b_ready_after_xfer", {31'd0, in_ready}, 32'd1);
        exp_val = 5'b0_0101;
        run_to(51);
        check("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        run_to(55);
        exp_val = 5'b0_0111;
        run_to(65);

        // Illegal units value 12 shows a dash and raises err.
        in_valid = 1'b1;
        in_bcd   = 5'b0_1100;
        run_to(66);
        in_valid = 1'b0;
        run_to(70);
        exp_val = 5'b0_1100;
        run_to(75);

        // Legal 9 clears err after the commit.
        in_valid = 1'b1;
        in_bcd   = 5'b0_1001;
        run_to(76);
        in_valid = 1'b0;
        run_to(80);
        exp_val = 5'b0_1001;
        run_to(86);

        // Reset during TENS with a word pending.
        in_valid = 1'b1;
        in_bcd   = 5'b1_0010;
        run_to(87);
        in_valid = 1'b0;
        check("pend_before_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_dig",   {30'd0, dig},      32'd0);
        check("mid_rst_seg",   {25'd0, seg},      32'd0);
        check("mid_rst_err",   {31'd0, err},      32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        rst      = 1'b0;
        k        = 0;
        exp_val  = 5'd0;
        prev_dig = dig;
        run_to(12);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
